lcd_static_drv: RTL
===================

# lcd_static_drv

Static (1:4-free, direct-drive) LCD glass driver sitting directly downstream of the Wishbone LCD register block, in the LCD clock domain (2 MHz). It takes the four 8-bit digit codes plus decimal-point and colon flags that block produces, decodes them to 7-segment patterns, and drives the glass with a DC-balanced AC waveform. The waveform is a common backplane square wave, with each segment line in phase (off) or anti-phase (on) with it. Display content updates only on full-frame boundaries, so no segment ever sees a net DC bias.

## Interface
- CLK_DIV, 16384, LCD_clk cycles per half-frame (backplane half-period); ≥2; 16384 at 2 MHz gives ≈61 Hz frame rate
- LCD_clk  input  1  LCD domain clock; all state on rising edge
- wb_rst_i  input  1  reset, asynchronous, active-high
- LCD_digit0..LCD_digit3  input  8 each  digit codes, already synchronised into LCD_clk domain
- LCD_decPt0..LCD_decPt2  input  1 each  decimal point flags
- LCD_colon  input  1  colon flag
- lcd_com_o  output  1  backplane drive
- lcd_seg_o  output  32  segment drives: [7i+6:7i] = digit i segments g..a (bit 7i = a); [28],[29],[30] = dp0,dp1,dp2; [31] = colon
- frame_o  output  1  one-cycle pulse on every full-frame boundary (shadow load)

## Operation
- Glyph decode (per digit code c), pattern bits g..a:
  - c[7]=1: raw mode, pattern = c[6:0]
  - 0x00–0x0F: hex glyphs 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71
  - 0x10: '-' = 40; 0x11: '_' = 08; every other code 0x12–0x7F: blank = 00
- Prescaler div_cnt counts 0..CLK_DIV-1, wraps to 0; terminal count (tc) = div_cnt==CLK_DIV-1.
- phase register toggles at every tc; lcd_com_o = phase.
- Shadow register (32 bits of decoded "on" states) loads decode of current inputs when:
  - load_init: first cycle after reset deassertion (init flag set in reset, cleared by that load), or
  - frame boundary: tc while phase==1 (end of the second half of a frame).
- frame_o = 1 for the cycle following any shadow load.
- lcd_seg_o = shadow XOR {32{phase}}, computed from next-state values and registered, so lcd_com_o and lcd_seg_o change on the same edge. On segment: opposite polarity to com. Off segment: equal polarity.
- Inputs are sampled only at load instants; changes between loads are ignored until the next boundary.
- Reset (any time, including mid-frame): div_cnt=0, phase=0, shadow=0, init=1, lcd_com_o=0, lcd_seg_o=0, frame_o=0. Operation restarts cleanly from the first half-frame after release.

## Timing
- Reset values: lcd_com_o=0, lcd_seg_o=32'h0, frame_o=0.
- Edge 1 after reset release: shadow loaded, lcd_seg_o = decoded pattern (phase 0), frame_o=1 on that cycle.
- Half-frame = CLK_DIV cycles; full frame = 2·CLK_DIV cycles; each segment spends exactly CLK_DIV cycles at each polarity per frame.
- Input-to-glass latency: 1 to 2·CLK_DIV cycles (next frame boundary).
- At a frame boundary, com goes 1→0, new pattern applies, and frame_o pulses, all on the same edge.
- Registered outputs only; no combinational path from inputs to outputs.

## Test plan
- Reset then release, CLK_DIV=4, digits=00,01,02,03, no dp/colon -> cycle 1: com=0, seg[6:0]=3F, [13:7]=06, [20:14]=5B, [27:21]=4F, [31:28]=0; frame_o=1 once.
- Free run, CLK_DIV=4 -> com toggles every 4 cycles; seg = ~pattern whenever com=1; frame_o pulses every 8 cycles, aligned with com 1→0.
- Change digit0 to 0x0E mid-frame -> seg[6:0] stays at old value until next frame boundary, then 79 (com=0); never changes while com=1.
- Codes 0x85 (raw), 0x10, 0x11, 0x55 plus decPt1=1, colon=1 -> seg digit fields 05,40,08,00; seg[29]=1, seg[31]=1, seg[28]=seg[30]=0 (phase 0).
- Assert wb_rst_i asynchronously mid half-frame -> all outputs 0 immediately; after release, reload on first edge and full 4-cycle half-frames resume.
- DC balance: run 100 frames with random input changes -> for every segment, count of cycles with seg≠com is even-split across com=0/com=1 within each frame (equal on-time per polarity).

Source files
------------

// File: rtl/lcd_static_drv.sv
// rtl/lcd_static_drv.sv - static direct-drive LCD glass driver with frame-aligned shadow load
//
// Purpose:
//   Decodes four digit codes plus decimal-point/colon flags into 7-segment
//   patterns and drives the glass with a DC-balanced AC waveform. The
//   backplane (com) is a square wave with a half-period of CLK_DIV cycles.
//   Each segment line is driven in phase with com when off and in anti-phase
//   when on. Display content is latched into a shadow register only on
//   full-frame boundaries, so every segment spends equal time at each polarity.
//
// Parameters:
//   CLK_DIV      LCD_clk cycles per half-frame (>= 2)
//
// Ports:
//   LCD_clk      in   LCD domain clock, all state on rising edge
//   wb_rst_i     in   asynchronous active-high reset
//   LCD_digit0-3 in   8-bit digit codes (already in LCD_clk domain)
//   LCD_decPt0-2 in   decimal point flags
//   LCD_colon    in   colon flag
//   lcd_com_o    out  backplane drive
//   lcd_seg_o    out  segment drives: [7i+6:7i] digit i (g..a), [28..30] dp0..dp2, [31] colon
//   frame_o      out  one-cycle pulse in the cycle following every shadow load

module lcd_static_drv #(
    parameter int CLK_DIV = 16384
) (
    input  logic        LCD_clk,
    input  logic        wb_rst_i,
    input  logic [7:0]  LCD_digit0,
    input  logic [7:0]  LCD_digit1,
    input  logic [7:0]  LCD_digit2,
    input  logic [7:0]  LCD_digit3,
    input  logic        LCD_decPt0,
    input  logic        LCD_decPt1,
    input  logic        LCD_decPt2,
    input  logic        LCD_colon,
    output logic        lcd_com_o,
    output logic [31:0] lcd_seg_o,
    output logic        frame_o
);

    localparam int              CNT_W  = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic             phase_q, phase_d;
    logic             init_q, init_d;
    logic [31:0]      shadow_q, shadow_d;
    logic [31:0]      seg_q, seg_d;
    logic             frame_q, frame_d;

    logic             tc;
    logic             load;
    logic [31:0]      decoded;

    // Code to segment pattern (bit 0 = a ... bit 6 = g).
    function automatic logic [6:0] glyph(input logic [7:0] c);
        logic [6:0] g;
        g = 7'h00;
        if (c[7]) begin
            g = c[6:0];
        end else begin
            case (c[6:0])
                7'h00:   g = 7'h3F;
                7'h01:   g = 7'h06;
                7'h02:   g = 7'h5B;
                7'h03:   g = 7'h4F;
                7'h04:   g = 7'h66;
                7'h05:   g = 7'h6D;
                7'h06:   g = 7'h7D;
                7'h07:   g = 7'h07;
                7'h08:   g = 7'h7F;
                7'h09:   g = 7'h6F;
                7'h0A:   g = 7'h77;
                7'h0B:   g = 7'h7C;
                7'h0C:   g = 7'h39;
                7'h0D:   g = 7'h5E;
                7'h0E:   g = 7'h79;
                7'h0F:   g = 7'h71;
                7'h10:   g = 7'h40;
                7'h11:   g = 7'h08;
                default: g = 7'h00;
            endcase
        end
        return g;
    endfunction

    always_comb begin
        decoded = {LCD_colon, LCD_decPt2, LCD_decPt1, LCD_decPt0,
                   glyph(LCD_digit3), glyph(LCD_digit2),
                   glyph(LCD_digit1), glyph(LCD_digit0)};

        tc        = (div_cnt_q == TC_VAL);
        div_cnt_d = tc ? '0 : div_cnt_q + CNT_W'(1);
        phase_d   = phase_q ^ tc;

        // Load right after reset, and at the end of the com=1 half so a new
        // pattern always starts a frame at com=0 and sees both polarities equally.
        load      = init_q | (tc & phase_q);
        init_d    = 1'b0;
        shadow_d  = load ? decoded : shadow_q;

        // Built from next-state values so com and seg switch on the same edge.
        seg_d     = shadow_d ^ {32{phase_d}};
        frame_d   = load;
    end

    always_ff @(posedge LCD_clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            div_cnt_q <= '0;
            phase_q   <= 1'b0;
            init_q    <= 1'b1;
            shadow_q  <= '0;
            seg_q     <= '0;
            frame_q   <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            phase_q   <= phase_d;
            init_q    <= init_d;
            shadow_q  <= shadow_d;
            seg_q     <= seg_d;
            frame_q   <= frame_d;
        end
    end

    assign lcd_com_o = phase_q;
    assign lcd_seg_o = seg_q;
    assign frame_o   = frame_q;

endmodule
